// File: rtl/lift_req_queue.sv
// Floor-call FIFO ahead of the lift controller: filters invalid/duplicate calls, buffers the rest in order.
// Optional LIFT_REQ_FLUSH_EN adds a flush input that empties the queue without a reset.
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LIFT_REQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  input  logic [2:0]       req_code,
  input  logic             pop,
  output logic [2:0]       head_code,
  output logic             q_empty,
  output logic             q_full,
  output logic [CNT_W-1:0] count,
  output logic             drop_inv,
  output logic             drop_dup,
  output logic             drop_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       pending_q, pending_d;
  logic             drop_inv_q, drop_inv_d;
  logic             drop_dup_q, drop_dup_d;
  logic             drop_full_q, drop_full_d;

  logic             empty, code_inv, pop_eff, is_dup, full_blk, push, clr;
  logic [2:0]       head;

`ifdef LIFT_REQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    code_inv = (req_code == 3'b000) || (req_code == 3'b101);
    pop_eff  = pop && !empty;
    // Re-pushing the code being popped this cycle is legal: it leaves the queue and re-enters at the tail.
    is_dup   = pending_q[req_code] && !(pop_eff && (head == req_code));
    full_blk = (count_q == CNT_W'(DEPTH)) && !pop_eff;

    drop_inv_d  = req_valid && code_inv;
    drop_dup_d  = req_valid && !code_inv && is_dup;
    drop_full_d = req_valid && !code_inv && !is_dup && full_blk;
    push        = req_valid && !code_inv && !is_dup && !full_blk;

    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (pop_eff) begin
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      pending_d[head] = 1'b0;
    end
    if (push) begin
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      pending_d[req_code] = 1'b1;
    end
    case ({push, pop_eff})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (clr) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      drop_inv_q  <= 1'b0;
      drop_dup_q  <= 1'b0;
      drop_full_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      drop_inv_q  <= drop_inv_d;
      drop_dup_q  <= drop_dup_d;
      drop_full_q <= drop_full_d;
    end
  end

  // Storage needs no reset: head_code is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= req_code;
  end

  assign head_code = empty ? 3'b000 : head;
  assign q_empty   = empty;
  assign q_full    = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign drop_inv  = drop_inv_q;
  assign drop_dup  = drop_dup_q;
  assign drop_full = drop_full_q;

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue (DEPTH=4 so the full path is reachable); define LIFT_REQ_FLUSH_EN to cover flush.
module tb_lift_req_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic [2:0]       req_code;
  logic             pop;
  logic [2:0]       head_code;
  logic             q_empty, q_full;
  logic [CNT_W-1:0] count;
  logic             drop_inv, drop_dup, drop_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lift_req_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LIFT_REQ_FLUSH_EN
    .flush     (flush),
`endif
    .req_valid (req_valid),
    .req_code  (req_code),
    .pop       (pop),
    .head_code (head_code),
    .q_empty   (q_empty),
    .q_full    (q_full),
    .count     (count),
    .drop_inv  (drop_inv),
    .drop_dup  (drop_dup),
    .drop_full (drop_full)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge that consumes them.
  task automatic step(input logic v, input logic [2:0] c, input logic p);
    req_valid = v;
    req_code  = c;
    pop       = p;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_code  = 3'b000;
    pop       = 1'b0;
    flush     = 1'b0;
  endtask

  // Full state check: count, head, empty, full, and {inv,dup,full} drop pulses.
  task automatic st(input string tag, input int c, input logic [2:0] h,
                    input logic e, input logic f, input logic [2:0] drops);
    chk({tag, "_count"}, 8'(count), 8'(c));
    chk({tag, "_head"},  8'(head_code), 8'(h));
    chk({tag, "_empty"}, 8'(q_empty), 8'(e));
    chk({tag, "_full"},  8'(q_full), 8'(f));
    chk({tag, "_drops"}, 8'({drop_inv, drop_dup, drop_full}), 8'(drops));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_code = 3'b000; pop = 1'b0;
    step(0, 3'b000, 0);
    step(0, 3'b000, 0);
    rst_n = 1'b1;
    st("reset", 0, 3'b000, 1, 0, 3'b000);

    // Basic ordered pushes
    step(1, 3'b001, 0); st("push1", 1, 3'b001, 0, 0, 3'b000);
    step(1, 3'b110, 0); st("push2", 2, 3'b001, 0, 0, 3'b000);
    step(1, 3'b100, 0); st("push3", 3, 3'b001, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("pop1",  2, 3'b110, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("pop2",  1, 3'b100, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("pop3",  0, 3'b000, 1, 0, 3'b000);

    // Duplicate and invalid filtering
    step(1, 3'b011, 0); st("dup_a",  1, 3'b011, 0, 0, 3'b000);
    step(1, 3'b011, 0); st("dup_b",  1, 3'b011, 0, 0, 3'b010);
    step(1, 3'b000, 0); st("inv000", 1, 3'b011, 0, 0, 3'b100);
    step(1, 3'b101, 0); st("inv101", 1, 3'b011, 0, 0, 3'b100);
    step(0, 3'b000, 0); st("idle",   1, 3'b011, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("drain",  0, 3'b000, 1, 0, 3'b000);

    // Fill to DEPTH, overflow, then push-with-pop while full (pointers wrap here)
    step(1, 3'b001, 0);
    step(1, 3'b010, 0);
    step(1, 3'b011, 0);
    step(1, 3'b110, 0); st("fill",     4, 3'b001, 0, 1, 3'b000);
    step(1, 3'b111, 0); st("overflow", 4, 3'b001, 0, 1, 3'b001);
    step(1, 3'b111, 1); st("fullpp",   4, 3'b010, 0, 1, 3'b000);
    step(0, 3'b000, 1); st("fpop1",    3, 3'b011, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("fpop2",    2, 3'b110, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("fpop3",    1, 3'b111, 0, 0, 3'b000);
    step(0, 3'b000, 1); st("fpop4",    0, 3'b000, 1, 0, 3'b000);

    // Same code pushed while being popped
    step(1, 3'b010, 0); st("only010",  1, 3'b010, 0, 0, 3'b000);
    step(1, 3'b010, 1); st("repush",   1, 3'b010, 0, 0, 3'b000);
    step(1, 3'b010, 0); st("still_pd", 1, 3'b010, 0, 0, 3'b010);

    // Pop while empty, then empty + push + pop
    step(0, 3'b000, 1); st("pop_last",  0, 3'b000, 1, 0, 3'b000);
    step(0, 3'b000, 1); st("pop_empty", 0, 3'b000, 1, 0, 3'b000);
    step(1, 3'b001, 1); st("emp_pp",    1, 3'b001, 0, 0, 3'b000);

    // Reset mid-operation
    step(1, 3'b010, 0);
    step(1, 3'b011, 0); st("pre_rst", 3, 3'b001, 0, 0, 3'b000);
    rst_n = 1'b0;
    step(0, 3'b000, 0);
    rst_n = 1'b1;
    st("mid_rst", 0, 3'b000, 1, 0, 3'b000);
    step(1, 3'b011, 0); st("post_rst", 1, 3'b011, 0, 0, 3'b000);

`ifdef LIFT_REQ_FLUSH_EN
    step(1, 3'b001, 0);
    step(1, 3'b010, 0); st("pre_flush", 3, 3'b011, 0, 0, 3'b000);
    flush = 1'b1;
    step(1, 3'b100, 1); st("flush",     0, 3'b000, 1, 0, 3'b000);
    step(1, 3'b100, 0); st("post_fl",   1, 3'b100, 0, 0, 3'b000);
    flush = 1'b1;
    step(1, 3'b100, 0); st("flush_dup", 0, 3'b000, 1, 0, 3'b010);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
